reg_file_64: RTL and testbench

- 32-entry × 64-bit architectural register file for the LEGv8-style datapath.
- Each entry is edge-triggered 64-bit storage. A single write port captures on the rising clock edge.
- Two independent read ports return the stored words to the ALU operand path.
- Register ZERO_REG is the hardwired zero register (XZR). It always reads 0 and ignores writes.

---
 rtl/reg_file_64.sv | 62 ++++++
 tb/tb_reg_file_64.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_64.sv
// 32 x 64-bit architectural register file: one synchronous write port,
// two combinational read ports, hardwired-zero register, optional write bypass.
module reg_file_64 #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    assign wr_en = reg_write && (write_reg != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Outputs are forced to zero while rst is high so reads never expose
    // pre-reset contents; the zero register never touches storage at all.
    always_comb begin
        read_data1 = '0;
        if (rst || read_reg1 == ZERO_IDX) begin
            read_data1 = '0;
        end else if (BYPASS && reg_write && write_reg == read_reg1) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (rst || read_reg2 == ZERO_IDX) begin
            read_data2 = '0;
        end else if (BYPASS && reg_write && write_reg == read_reg2) begin
            read_data2 = write_data;
        end else begin
            read_data2 = regs[read_reg2];
        end
    end

endmodule

// File: tb/tb_reg_file_64.sv
// Directed bench for reg_file_64: one bypassing and one non-bypassing instance
// driven from the same stimulus, checked against hand-computed vectors.
module tb_reg_file_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] rd1, rd2, nb1, nb2;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_64 dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1), .read_data2(rd2)
    );

    reg_file_64 #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nb1), .read_data2(nb2)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] n1;
        logic [63:0] n2;
    } vec_t;

    vec_t        vecs [16];
    logic [63:0] model [32];

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wr,
                                input logic [63:0] wd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [63:0] e1,
                                input logic [63:0] e2, input logic [63:0] n1,
                                input logic [63:0] n2);
        vec_t v;
        v.rst = r; v.we = we; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2;
        v.e1 = e1; v.e2 = e2; v.n1 = n1; v.n2 = n2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later,
    // well before the next rising edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst = r; reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = r1; read_reg2 = r2;
        #1;
    endtask

    localparam logic [63:0] V_DEAD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] V_X1   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] V_AAAA = 64'hAAAA_AAAA_AAAA_AAAA;

    initial begin
        rst = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;

        //               rst we  wr  wd          r1  r2  e1(byp)  e2(byp)  n1(nobyp) n2(nobyp)
        vecs[0]  = mk(1'b0, 1'b1, 5,  V_DEAD,      5, 31, V_DEAD,  64'h0,   64'h0,    64'h0);
        vecs[1]  = mk(1'b1, 1'b0, 0,  64'h0,       5,  0, 64'h0,   64'h0,   64'h0,    64'h0);
        vecs[2]  = mk(1'b0, 1'b0, 0,  64'h0,       5,  6, 64'h0,   64'h0,   64'h0,    64'h0);
        vecs[3]  = mk(1'b0, 1'b1, 1,  V_X1,        1,  2, V_X1,    64'h0,   64'h0,    64'h0);
        vecs[4]  = mk(1'b0, 1'b1, 2,  V_ONES,      1,  2, V_X1,    V_ONES,  V_X1,     64'h0);
        vecs[5]  = mk(1'b0, 1'b0, 0,  64'h0,       1,  2, V_X1,    V_ONES,  V_X1,     V_ONES);
        vecs[6]  = mk(1'b0, 1'b0, 0,  64'h0,       3, 31, 64'h0,   64'h0,   64'h0,    64'h0);
        vecs[7]  = mk(1'b0, 1'b1, 31, V_AAAA,     31,  1, 64'h0,   V_X1,    64'h0,    V_X1);
        vecs[8]  = mk(1'b0, 1'b0, 0,  64'h0,      31,  2, 64'h0,   V_ONES,  64'h0,    V_ONES);
        vecs[9]  = mk(1'b0, 1'b1, 7,  64'h10,      0,  7, 64'h0,   64'h10,  64'h0,    64'h0);
        vecs[10] = mk(1'b0, 1'b1, 7,  64'h20,      7,  7, 64'h20,  64'h20,  64'h10,   64'h10);
        vecs[11] = mk(1'b0, 1'b0, 0,  64'h0,       7,  7, 64'h20,  64'h20,  64'h20,   64'h20);
        vecs[12] = mk(1'b1, 1'b1, 4,  64'h55,      4,  1, 64'h0,   64'h0,   64'h0,    64'h0);
        vecs[13] = mk(1'b0, 1'b0, 0,  64'h0,       4,  1, 64'h0,   64'h0,   64'h0,    64'h0);
        vecs[14] = mk(1'b0, 1'b1, 4,  64'h66,      4,  2, 64'h66,  64'h0,   64'h0,    64'h0);
        vecs[15] = mk(1'b0, 1'b0, 0,  64'h0,       4,  4, 64'h66,  64'h66,  64'h66,   64'h66);

        // Initial reset: outputs zero while rst is high and every index zero after.
        drive(1'b1, 1'b0, 0, 64'h0, 5, 9);
        check("rst_during.rd1", rd1, 64'h0);
        check("rst_during.nb2", nb2, 64'h0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 0, 64'h0, 5'(i), 5'(31 - i));
            check($sformatf("post_rst.rd1[%0d]", i), rd1, 64'h0);
            check($sformatf("post_rst.nb2[%0d]", 31 - i), nb2, 64'h0);
        end

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            check($sformatf("vec%0d.rd1", i), rd1, vecs[i].e1);
            check($sformatf("vec%0d.rd2", i), rd2, vecs[i].e2);
            check($sformatf("vec%0d.nb1", i), nb1, vecs[i].n1);
            check($sformatf("vec%0d.nb2", i), nb2, vecs[i].n2);
        end

        // Fill every writable entry, then hold for 10 cycles with noisy write inputs.
        for (int i = 0; i < 31; i++) begin
            model[i] = {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h0101_0101};
            drive(1'b0, 1'b1, 5'(i), model[i], 0, 0);
        end
        model[31] = 64'h0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 0, 64'h0, 5'(i), 5'(i));
            check($sformatf("hold.rd1[%0d]", i), rd1, model[i]);
            check($sformatf("hold.rd2[%0d]", i), rd2, model[i]);
            check($sformatf("hold.nb1[%0d]", i), nb1, model[i]);
        end

        // Zero-register write must leave every entry intact and never bypass.
        drive(1'b0, 1'b1, 31, V_AAAA, 31, 30);
        check("zwrite.rd1", rd1, 64'h0);
        check("zwrite.rd2", rd2, model[30]);
        drive(1'b0, 1'b0, 0, 64'h0, 31, 0);
        check("zafter.rd1", rd1, 64'h0);
        check("zafter.rd2", rd2, model[0]);

        // Reset mid-sequence clears everything, then a normal write resumes.
        drive(1'b1, 1'b0, 0, 64'h0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 0, 64'h0, 5'(i), 5'(i));
            check($sformatf("reclr.rd1[%0d]", i), rd1, 64'h0);
            check($sformatf("reclr.nb2[%0d]", i), nb2, 64'h0);
        end
        drive(1'b0, 1'b1, 12, 64'h1234, 0, 0);
        drive(1'b0, 1'b0, 0, 64'h0, 12, 13);
        check("rewrite.rd1", rd1, 64'h1234);
        check("rewrite.rd2", rd2, 64'h0);
        check("rewrite.nb1", nb1, 64'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
